// File: rtl/alu_pkg.sv
// Shared definitions for the wide-arithmetic sequencer: state encoding,
// byte width and the byte-index width helper.
package alu_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte index width; at least one bit so NBYTES=1 still has a legal index.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Start/done handshake plus operand and result/flag bus between the control
// FSM (master) and the multi-byte adder sequencer (slave).
interface multibyte_add_sequencer_if
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
);

  localparam int unsigned W = NBYTES * BYTE_W;

  logic         start;
  logic         op_sub;
  logic         use_carry;
  logic         carry_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  modport master (
    output start, op_sub, use_carry, carry_in, a, b,
    input  ready, done, result, carry_out, zero, overflow
  );

  modport slave (
    input  start, op_sub, use_carry, carry_in, a, b,
    output ready, done, result, carry_out, zero, overflow
  );

endinterface

// File: rtl/Carry_Select_Adder.sv
// 8-bit carry-select adder: low nibble ripples, high nibble is precomputed
// for both carry values and selected by the low-nibble carry.
module Carry_Select_Adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] sum_out,
  output logic       Cout
);

  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;
  logic [4:0] w_hi;

  assign w_lo  = 5'(A[3:0]) + 5'(B[3:0]) + 5'(Cin);
  assign w_hi0 = 5'(A[7:4]) + 5'(B[7:4]);
  assign w_hi1 = 5'(A[7:4]) + 5'(B[7:4]) + 5'd1;
  assign w_hi  = w_lo[4] ? w_hi1 : w_hi0;

  assign sum_out = {w_hi[3:0], w_lo[3:0]};
  assign Cout    = w_hi[4];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Wide ADD/SUB/ADC/SBC unit: time-shares one 8-bit adder over NBYTES byte
// slices, LSB first, chaining carry and accumulating zero/overflow flags.
module multibyte_add_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NBYTES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multibyte_add_sequencer_if.slave   bus
);

  localparam int unsigned W     = NBYTES * BYTE_W;
  localparam int unsigned IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_ready;
  logic               r_done;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_sub;
  logic               r_carry;
  logic               r_zero_acc;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_result;
  logic               r_carry_out;
  logic               r_zero;
  logic               r_overflow;

  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic [BYTE_W-1:0]  w_b_eff;
  logic [BYTE_W-1:0]  w_sum;
  logic               w_cout;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_run    = (r_state == RUN);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_b_eff  = r_b[BYTE_W-1:0] ^ {BYTE_W{r_sub}};

  Carry_Select_Adder u_csa (
    .A       (r_a[BYTE_W-1:0]),
    .B       (w_b_eff),
    .Cin     (r_carry),
    .sum_out (w_sum),
    .Cout    (w_cout)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:                   w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // State register; ready/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      r_done  <= (w_next == DONE);
    end
  end

  // Operands shift down one byte per RUN cycle so the adder always sees byte 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_carry     <= 1'b0;
      r_zero_acc  <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      r_a        <= bus.a;
      r_b        <= bus.b;
      r_sub      <= bus.op_sub;
      r_carry    <= bus.use_carry ? bus.carry_in : bus.op_sub;
      r_zero_acc <= 1'b1;
      r_idx      <= '0;
    end else if (w_run) begin
      r_result[r_idx*BYTE_W +: BYTE_W] <= w_sum;
      r_carry    <= w_cout;
      r_zero_acc <= r_zero_acc & (w_sum == '0);
      r_idx      <= r_idx + IDX_W'(1);
      r_a        <= r_a >> BYTE_W;
      r_b        <= r_b >> BYTE_W;
      if (w_last) begin
        r_carry_out <= w_cout;
        r_zero      <= r_zero_acc & (w_sum == '0);
        r_overflow  <= (r_a[BYTE_W-1] == w_b_eff[BYTE_W-1]) &&
                       (w_sum[BYTE_W-1] != r_a[BYTE_W-1]);
      end
    end
  end

  assign bus.ready     = r_ready;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Self-checking bench for multibyte_add_sequencer: directed and random
// operations compared against a full-width arithmetic reference model.
module tb_multibyte_add_sequencer;

  localparam int unsigned N = 2;
  localparam int unsigned W = N * 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  multibyte_add_sequencer_if #(.NBYTES(N)) bus ();

  multibyte_add_sequencer #(.NBYTES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: whole-operand arithmetic, no byte slicing.
  task automatic model(input logic sub, input logic uc, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c,
                       output logic z, output logic o);
    logic [W-1:0] be;
    logic [W:0]   s;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + (W+1)'(uc ? cin : sub);
    r  = s[W-1:0];
    c  = s[W];
    z  = (r == '0);
    o  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
  endtask

  task automatic drive(input logic sub, input logic uc, input logic cin,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_sub    = sub;
    bus.use_carry = uc;
    bus.carry_in  = cin;
    bus.a         = a;
    bus.b         = b;
  endtask

  task automatic scramble();
    drive(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] er,
                              input logic ec, input logic ez, input logic eo);
    check({tag, "_result"},   64'(bus.result),    64'(er));
    check({tag, "_carry"},    64'(bus.carry_out), 64'(ec));
    check({tag, "_zero"},     64'(bus.zero),      64'(ez));
    check({tag, "_overflow"}, 64'(bus.overflow),  64'(eo));
    check({tag, "_ready_in_done"}, 64'(bus.ready), 64'd0);
  endtask

  task automatic run_op(input logic sub, input logic uc, input logic cin,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit glitch, input string tag);
    logic [W-1:0] er;
    logic ec, ez, eo;
    int   cyc;
    bit   seen;
    model(sub, uc, cin, a, b, er, ec, ez, eo);
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    drive(sub, uc, cin, a, b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_ready_run"}, 64'(bus.ready), 64'd0);
        if (glitch) begin
          scramble();
          bus.start = 1'b1;
        end
      end else if (cyc == 2) begin
        bus.start = 1'b0;
      end
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(N + 1));
    if (seen) check_result(tag, er, ec, ez, eo);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
    // An ignored start must not be queued into a second operation.
    if (glitch) begin
      repeat (N + 2) begin
        @(negedge clk);
        check({tag, "_no_extra_done"}, 64'(bus.done), 64'd0);
      end
    end
  endtask

  task automatic held_start();
    logic [W-1:0] a1, b1, a2, b2, er1, er2;
    logic ec1, ez1, eo1, ec2, ez2, eo2;
    int   j;
    int   cyc;
    bit   got1;
    bit   seen;
    a1 = W'($urandom); b1 = W'($urandom);
    a2 = W'($urandom); b2 = W'($urandom);
    model(1'b0, 1'b0, 1'b0, a1, b1, er1, ec1, ez1, eo1);
    model(1'b1, 1'b0, 1'b0, a2, b2, er2, ec2, ez2, eo2);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, a1, b1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, a2, b2);
    j    = 0;
    got1 = 1'b0;
    while (j < 20) begin
      @(negedge clk);
      j++;
      if (bus.done && !got1) begin
        got1 = 1'b1;
        check_result("held1", er1, ec1, ez1, eo1);
      end
      if (bus.ready) break;
    end
    check("held_spacing", 64'(j), 64'(N + 2));
    check("held_first_done", 64'(got1), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
    end
    check("held2_latency", 64'(cyc), 64'(N + 1));
    if (seen) check_result("held2", er2, ec2, ez2, eo2);
    @(negedge clk);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, W'(16'h1234), W'(16'h1111));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready",    64'(bus.ready),     64'd1);
    check("rst_mid_done",     64'(bus.done),      64'd0);
    check("rst_mid_result",   64'(bus.result),    64'd0);
    check("rst_mid_carry",    64'(bus.carry_out), 64'd0);
    check("rst_mid_zero",     64'(bus.zero),      64'd0);
    check("rst_mid_overflow", 64'(bus.overflow),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) begin
      @(negedge clk);
      check("rst_no_done", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.start = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready",    64'(bus.ready),     64'd1);
    check("reset_done",     64'(bus.done),      64'd0);
    check("reset_result",   64'(bus.result),    64'd0);
    check("reset_carry",    64'(bus.carry_out), 64'd0);
    check("reset_zero",     64'(bus.zero),      64'd0);
    check("reset_overflow", 64'(bus.overflow),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 1'b0, 1'b0, W'(16'h12AA), W'(16'h3443), 1'b0, "add_basic");
    run_op(1'b0, 1'b0, 1'b0, W'(16'hFFFF), W'(16'h0001), 1'b0, "add_wrap");
    run_op(1'b0, 1'b0, 1'b0, W'(16'h7FFF), W'(16'h0001), 1'b0, "add_ovf");
    run_op(1'b1, 1'b0, 1'b0, W'(16'h0100), W'(16'h0001), 1'b0, "sub_borrow_chain");
    run_op(1'b1, 1'b0, 1'b0, W'(16'h0000), W'(16'h0001), 1'b0, "sub_under");
    run_op(1'b0, 1'b1, 1'b1, W'(16'h00FF), W'(16'h0000), 1'b0, "adc");
    run_op(1'b1, 1'b1, 1'b0, W'(16'h0005), W'(16'h0002), 1'b0, "sbc");
    run_op(1'b1, 1'b0, 1'b0, W'(16'h8000), W'(16'h0001), 1'b0, "sub_ovf");
    run_op(1'b0, 1'b0, 1'b0, W'(16'h1234), W'(16'h4321), 1'b1, "glitch");

    held_start();
    reset_mid_run();
    run_op(1'b0, 1'b0, 1'b0, W'(16'h12AA), W'(16'h3443), 1'b0, "post_reset");

    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), 1'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multibyte_add_sequencer.md
# multibyte_add_sequencer

Sequences the 8-bit `Carry_Select_Adder` over multi-byte operands, one byte per clock, least-significant byte first. The block chains carry between byte slices and supports ADD/SUB, with or without an external carry-in (ADC/SBC style). It produces carry, zero and signed-overflow flags. It sits in the CPU execute stage as the wide-arithmetic unit behind the 8-bit ALU, driven by the control FSM via a start/done handshake.

## Interface
- `NBYTES`, default 2: operand width in bytes; legal values are 1 to 8.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation; accepted only while `ready`=1.
- `op_sub` in 1: 0 = A+B, 1 = A−B (B is inverted per byte).
- `use_carry` in 1: 1 = the initial carry is `carry_in`; 0 = the initial carry is `op_sub`.
- `carry_in` in 1: external carry, 6502 convention (1 = no borrow on SUB).
- `a` in 8·NBYTES: operand A, sampled on the accepting edge.
- `b` in 8·NBYTES: operand B, sampled on the accepting edge.
- `ready` out 1: high in IDLE only.
- `done` out 1: one-cycle pulse when the result and flags become valid.
- `result` out 8·NBYTES: sum or difference.
- `carry_out` out 1: carry out of the top byte.
- `zero` out 1: 1 when `result` is all zeros.
- `overflow` out 1: two's-complement overflow of the full-width operation.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`: latch A, B and `op_sub`. Set idx=0. Set carry to `use_carry ? carry_in : op_sub`. Clear the zero accumulator to 1.
  - RUN: the adder receives A[idx], B[idx] XOR {8{op_sub}}, and carry.
    - On each edge: write the sum byte to result[idx], set carry to adder Cout, AND the accumulator with (sum byte == 0), increment idx.
    - When idx = NBYTES−1, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Flag rules:
  - `carry_out` is the final carry.
  - `zero` is the accumulator.
  - `overflow` = (A msb == effective-B msb) && (result msb != A msb), evaluated on the top byte.
- Outputs hold their values from DONE until the next accepted start. `result` bytes update progressively during RUN; consumers use them only on `done`.
- `start` while not `ready` is ignored and not queued. The operands of an ignored start are not sampled.
- `op_sub`, `use_carry` and `carry_in` are sampled only on the accepting edge. Changes during RUN have no effect.
- NBYTES=1: RUN lasts one cycle.

## Timing
- Reset (async assert, synchronous-to-clk deassert handled upstream):
  - state=IDLE, `ready`=1, `done`=0.
  - `result`=0, `carry_out`=0, `zero`=0, `overflow`=0.
- Reset mid-RUN or in DONE aborts immediately. No `done` pulse follows.
- Latency:
  - `start` accepted at edge E.
  - `done` is high during the cycle after edge E+NBYTES.
  - `ready` returns high after edge E+NBYTES+1.
  - Throughput is one operation per NBYTES+2 cycles.
- `start` held high continuously: a new operation is accepted on the first edge with `ready`=1. Back-to-back operations are therefore spaced by NBYTES+2 edges.
- The adder path is combinational within one cycle. No multicycle paths are allowed.

## Structure
- Shared package `alu_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - byte-width constant `BYTE_W`=8.
  - index width `$clog2(NBYTES)` helper.
- One sub-module: the existing `Carry_Select_Adder` (ports A, B, Cin, sum_out, Cout), instantiated once and time-shared across bytes.
- Internal registers: operand shift/index muxes, carry, idx, zero accumulator.

## Test plan
- NBYTES=2, ADD, `use_carry`=0: A=0x12AA, B=0x3443 → `done` 2 edges after accept; result=0x46ED, carry=0, zero=0, overflow=0.
- ADD: 0xFFFF+0x0001 → result=0x0000, carry=1, zero=1, overflow=0. ADD: 0x7FFF+0x0001 → result=0x8000, carry=0, overflow=1.
- SUB, `use_carry`=0: 0x0100−0x0001 → result=0x00FF, carry=1 (no borrow), overflow=0. SUB: 0x0000−0x0001 → result=0xFFFF, carry=0.
- ADC: `use_carry`=1, `carry_in`=1, A=0x00FF, B=0x0000 → result=0x0100, carry=0. SBC with `carry_in`=0: 0x0005−0x0002 → 0x0002.
- `start` pulsed during RUN with different operands → ignored; the first result is unchanged and exactly one `done` pulse occurs. `start` held high → the second accept happens exactly NBYTES+2 edges after the first.
- Assert `rst_n`=0 mid-RUN → outputs are 0, `ready`=1 and `done`=0 immediately. After release, a fresh ADD completes correctly.
